// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes, oversample default
// and the data-bit clamp used when a frame's configuration is captured.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  // Out-of-range requests saturate to the nearest supported frame width.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0]  req,
                                                 input int unsigned max_bits);
    if (req < 4'd5) return 4'd5;
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div_i and pulses tick_o on terminal count.
// A synchronous restart realigns the tick phase to a detected start edge.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // NOTE: defaults first so every path assigns cnt_d/tick_o and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_o = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == div_i) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  // NOTE: flops use <= so every register samples pre-edge values together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-9 data bits, none/odd/even parity,
// 1 or 2 stop bits, 16x oversampling, parity/framing/break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_W         = 16,
  parameter int OVERSAMPLE    = OVERSAMPLE_DEF
) (
  input  logic                     i_System_Clock,
  input  logic                     i_Rst_L,
  input  logic [DIV_W-1:0]         i_Baud_Div,
  input  logic [3:0]               i_Data_Bits,
  input  logic [1:0]               i_Parity_Mode,
  input  logic                     i_Stop_Bits,
  input  logic                     i_RX_Serial,
  output logic                     o_RX_Busy,
  output logic                     o_RX_Done,
  output logic [MAX_DATA_BITS-1:0] o_RX_Byte,
  output logic                     o_Parity_Err,
  output logic                     o_Frame_Err,
  output logic                     o_Break
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  // Synchroniser and edge history idle high so reset never looks like a start edge.
  logic sync1_q, sync2_q, prev_q;

  rx_state_e                state_q, state_d;
  logic [OS_W-1:0]          os_q, os_d;
  logic [3:0]               bit_q, bit_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_acc_q, par_acc_d;
  logic                     ferr_acc_q, ferr_acc_d;
  logic [3:0]               nbits_q, nbits_d;
  logic [1:0]               pmode_q, pmode_d;
  logic                     two_stop_q, two_stop_d;
  logic [DIV_W-1:0]         div_q, div_d;

  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic [MAX_DATA_BITS-1:0] byte_q, byte_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     brk_q, brk_d;

  logic tick, restart, start_det, bit_sample, par_fail, is_break, finish;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk_i     (i_System_Clock),
    .rst_n_i   (i_Rst_L),
    .restart_i (restart),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  assign start_det  = (state_q == ST_IDLE) && prev_q && !sync2_q;
  assign bit_sample = tick && (os_q == OS_LAST);
  assign is_break   = !sync2_q && (shreg_q == '0) && !par_acc_q;

  // par_acc_q already includes the parity bit once the FSM reaches the stop bits.
  always_comb begin
    unique case (pmode_q)
      PAR_ODD:  par_fail = ~par_acc_q;
      PAR_EVEN: par_fail = par_acc_q;
      default:  par_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_acc_d  = par_acc_q;
    ferr_acc_d = ferr_acc_q;
    nbits_d    = nbits_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    byte_d     = byte_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    restart    = 1'b0;
    finish     = 1'b0;

    if (tick && state_q inside {ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2})
      os_d = bit_sample ? '0 : os_q + OS_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          restart    = 1'b1;
          state_d    = ST_START;
          os_d       = '0;
          bit_d      = '0;
          shreg_d    = '0;
          par_acc_d  = 1'b0;
          ferr_acc_d = 1'b0;
          nbits_d    = clamp_data_bits(i_Data_Bits, MAX_DATA_BITS);
          pmode_d    = (i_Parity_Mode == PAR_ODD || i_Parity_Mode == PAR_EVEN)
                       ? i_Parity_Mode : PAR_NONE;
          two_stop_d = i_Stop_Bits;
          div_d      = i_Baud_Div;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_q == OS_MID) begin
            os_d    = '0;
            state_d = sync2_q ? ST_IDLE : ST_DATA;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (bit_sample) begin
          for (int i = 0; i < MAX_DATA_BITS; i++)
            if (4'(i) == bit_q) shreg_d[i] = sync2_q;
          par_acc_d = par_acc_q ^ sync2_q;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = (pmode_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_sample) begin
          par_acc_d = par_acc_q ^ sync2_q;
          state_d   = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bit_sample) begin
          if (is_break) begin
            finish  = 1'b1;
            state_d = ST_BRK_WAIT;
          end else if (two_stop_q) begin
            ferr_acc_d = ferr_acc_q | ~sync2_q;
            state_d    = ST_STOP2;
          end else begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (bit_sample) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BRK_WAIT: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      byte_d = shreg_q;
      perr_d = par_fail;
      ferr_d = ferr_acc_q | ~sync2_q;
      brk_d  = (state_q == ST_STOP1) && is_break;
    end

    done_d = finish;
    busy_d = (state_d != ST_IDLE) || finish;
  end

  always_ff @(posedge i_System_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      os_q       <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_acc_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      nbits_q    <= '0;
      pmode_q    <= PAR_NONE;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync1_q    <= i_RX_Serial;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_acc_q  <= par_acc_d;
      ferr_acc_q <= ferr_acc_d;
      nbits_q    <= nbits_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      byte_q     <= byte_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign o_RX_Busy    = busy_q;
  assign o_RX_Done    = done_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brk_q;

endmodule
